// File: rtl/sys_ctrl_cmd_decoder.sv
// Command-frame decoder: parses synchronized RX bytes into register writes/reads and ALU
// operations, and queues response bytes into the TX FIFO. All outputs registered.
module sys_ctrl_cmd_decoder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_W-1:0]     ADDR,
  output logic                  WR_EN,
  output logic [DATA_W-1:0]     WR_DATA,
  output logic                  RD_EN,
  input  logic [DATA_W-1:0]     RD_DATA,
  input  logic                  RD_DATA_VLD,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  input  logic [2*DATA_W-1:0]   ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic                  CLK_GATE_EN,
  output logic [DATA_W-1:0]     TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  FIFO_FULL
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_ALU = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_FUN = DATA_W'(8'hDD);
  localparam logic [DATA_W-1:0] ERR_RSP = DATA_W'(8'hEE);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_TX_RD, S_OPA, S_OPB,
    S_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI, S_TX_ERR
  } state_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     addr_lat_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wr_en_q;
  logic [DATA_W-1:0]     wr_data_q;
  logic                  rd_en_q;
  logic                  alu_en_q;
  logic [3:0]            alu_fun_q;
  logic                  gate_q;
  logic [DATA_W-1:0]     tx_data_q;
  logic                  tx_vld_q;
  logic [2*DATA_W-1:0]   res_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      addr_lat_q <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      gate_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      res_q      <= '0;
      cnt_q      <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      alu_en_q <= 1'b0;
      tx_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR) begin
              state_q <= S_WR_ADDR;
            end else if (RX_P_DATA == CMD_RD) begin
              state_q <= S_RD_ADDR;
            end else if (RX_P_DATA == CMD_ALU) begin
              state_q <= S_OPA;
              gate_q  <= 1'b1;
            end else if (RX_P_DATA == CMD_FUN) begin
              state_q <= S_FUN;
              gate_q  <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_lat_q <= RX_P_DATA[ADDR_W-1:0];
            state_q    <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (RX_D_VLD) begin
            wr_en_q   <= 1'b1;
            addr_q    <= addr_lat_q;
            wr_data_q <= RX_P_DATA;
            state_q   <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (RX_D_VLD) begin
            rd_en_q <= 1'b1;
            addr_q  <= RX_P_DATA[ADDR_W-1:0];
            cnt_q   <= '0;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // A valid arriving on the last counted cycle still beats the timeout.
          if (RD_DATA_VLD) begin
            res_q[DATA_W-1:0] <= RD_DATA;
            state_q           <= S_TX_RD;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_q <= S_TX_ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_TX_RD: begin
          if (!FIFO_FULL) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= res_q[DATA_W-1:0];
            state_q   <= S_IDLE;
          end
        end
        S_OPA: begin
          if (RX_D_VLD) begin
            wr_en_q   <= 1'b1;
            addr_q    <= ADDR_W'(0);
            wr_data_q <= RX_P_DATA;
            state_q   <= S_OPB;
          end
        end
        S_OPB: begin
          if (RX_D_VLD) begin
            wr_en_q   <= 1'b1;
            addr_q    <= ADDR_W'(1);
            wr_data_q <= RX_P_DATA;
            state_q   <= S_FUN;
          end
        end
        S_FUN: begin
          if (RX_D_VLD) begin
            alu_en_q  <= 1'b1;
            alu_fun_q <= RX_P_DATA[3:0];
            cnt_q     <= '0;
            state_q   <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            res_q   <= ALU_OUT;
            state_q <= S_TX_LO;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_q <= S_TX_ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_TX_LO: begin
          if (!FIFO_FULL) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= res_q[DATA_W-1:0];
            state_q   <= S_TX_HI;
          end
        end
        S_TX_HI: begin
          if (!FIFO_FULL) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= res_q[2*DATA_W-1:DATA_W];
            gate_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_TX_ERR: begin
          if (!FIFO_FULL) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= ERR_RSP;
            gate_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          gate_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ADDR        = addr_q;
  assign WR_EN       = wr_en_q;
  assign WR_DATA     = wr_data_q;
  assign RD_EN       = rd_en_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;

endmodule
